multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Main control FSM for the multi-cycle build of our RV32I core: one shared instruction/data memory, a single ALU reused for PC+4, branch target and execute.
- Sequences IR/PC/register/memory write enables and all datapath mux selects per instruction phase.
- Waits on a memory ready handshake and counts retired instructions.
- Replaces the single-cycle controlunit when the core is built in multi-cycle mode.

Parameters:
- CNT_WIDTH, 32, width of the retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- op  input  7  Instr[6:0] from the instruction register
- funct3  input  3  Instr[14:12]
- funct7_5  input  1  Instr[30]
- Zero  input  1  ALU equality flag
- mem_ready  input  1  memory access completes this cycle
- PCWrite  output  1  PC register enable
- AdrSrc  output  1  memory address: 0=PC, 1=ALUOut
- MemWrite  output  1  memory write enable
- IRWrite  output  1  latch Instr and OldPC
- ResultSrc  output  2  00=ALUOut, 01=Data, 10=ALUResult
- ALUSrcA  output  2  00=PC, 01=OldPC, 10=RD1 register
- ALUSrcB  output  2  00=RD2 register, 01=ImmExt, 10=constant 4
- ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt
- ImmSrc  output  2  00 I, 01 S, 10 B, 11 J
- RegWrite  output  1  register file WE3
- illegal  output  1  one-cycle pulse on an unsupported opcode
- retire  output  1  one-cycle pulse when an instruction completes
- instret  output  CNT_WIDTH  retired-instruction count

Behaviour:
- Reset (async, active-high):
  - State goes to FETCH and instret goes to 0.
  - All write enables, illegal and retire go to 0.
- Outputs:
  - Moore-style from state, except PCWrite and IRWrite in FETCH and PCWrite in BEQ.
  - ALUControl is decoded from state (ALUOp) plus funct bits.
  - ImmSrc is combinational from op in every state: lw/addi-class 00, sw 01, beq 10, jal 11, other 00.
- ALUOp encoding:
  - 00 gives add.
  - 01 gives sub.
  - 10 gives funct decode:
    - funct3 000: sub if op[5]&funct7_5, else add.
    - 010: slt. 110: or. 111: and.
    - Any other funct3: add.
- States and outputs (unlisted controls = 0, selects = 00):
  - FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ALUOp 00, ResultSrc=10. IRWrite=PCWrite=mem_ready. Stay while !mem_ready, else go to DECODE.
  - DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp 00 (branch/jump target into ALUOut). Next state by op:
    - 0000011 or 0100011 -> MEMADR
    - 0110011 -> EXECUTER
    - 0010011 -> EXECUTEI
    - 1100011 -> BEQ
    - 1101111 -> JAL
    - other -> FETCH with illegal=1 for one cycle; no retire.
  - MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp 00. Go to MEMREAD if op[5]=0, else MEMWRITE.
  - MEMREAD: AdrSrc=1. Hold until mem_ready, then go to MEMWB.
  - MEMWB: ResultSrc=01, RegWrite=1, retire=1. Go to FETCH.
  - MEMWRITE: AdrSrc=1, MemWrite=1, held stable until mem_ready. Then retire=1 in the same cycle and go to FETCH.
  - EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp 10. Go to ALUWB.
  - EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp 10. Go to ALUWB.
  - ALUWB: ResultSrc=00, RegWrite=1, retire=1. Go to FETCH.
  - BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp 01, ResultSrc=00, PCWrite=Zero, retire=1. Go to FETCH.
  - JAL: ALUSrcA=01, ALUSrcB=10, ALUOp 00, ResultSrc=00, PCWrite=1. Go to ALUWB (writes OldPC+4 to rd).
- Latency (mem_ready always 1):
  - lw: 5 cycles.
  - sw, R-type, I-ALU, jal: 4 cycles.
  - beq: 3 cycles.
  - Each cycle of mem_ready=0 adds exactly one cycle.
- instret:
  - Increments by 1 on each retire cycle.
  - Wraps from all-ones to 0 with no flag.
- Reset mid-operation:
  - FSM returns to FETCH immediately.
  - Any asserted MemWrite/RegWrite/PCWrite deasserts asynchronously.
  - No partial retire is counted.
- mem_ready is ignored in states that do no memory access.

Decomposition:
- Package ctrl_pkg:
  - state_t enum (11 states).
  - Opcode localparams: OP_LOAD, OP_STORE, OP_R, OP_I, OP_BRANCH, OP_JAL.
  - ALU_ADD/SUB/AND/OR/SLT codes.
  - ALUOp codes.
  - SrcA/SrcB/ResultSrc select constants.
- One sub-module, alu_decoder (combinational): ALUOp, funct3, op[5], funct7_5 in; ALUControl out.
- State register, next-state logic, output decode and counter stay in the top.

Test Plan:
- Reset: assert rst mid-cycle, mem_ready=1 -> state FETCH, instret=0, PCWrite/MemWrite/RegWrite all 0 asynchronously before the next edge.
- lw with stalls: op=0000011, mem_ready=0 for 2 cycles in FETCH and 1 in MEMREAD -> 8 cycles total. IRWrite and PCWrite high only on the mem_ready FETCH cycle. RegWrite=1 with ResultSrc=01 in MEMWB. instret 0->1.
- sub then slt: op=0110011, funct3=000, funct7_5=1 -> ALUControl=001 in EXECUTER. Then funct3=010 -> 101. RegWrite in ALUWB. 4 cycles each.
- beq: Zero=1 -> PCWrite=1 in BEQ, ResultSrc=00, 3 cycles. Repeat with Zero=0 -> PCWrite=0, retire still 1.
- sw with stall: op=0100011, mem_ready=0 for 3 cycles in MEMWRITE -> MemWrite=1 and AdrSrc=1 stable for all 4 cycles, then FETCH. RegWrite never asserted.
- Illegal opcode: op=0000000 -> illegal pulses 1 cycle in DECODE, back to FETCH, instret unchanged. Force instret=all-ones, then retire -> wraps to 0.

Source files
------------

// File: rtl/ctrl_pkg.sv
// Shared definitions for the multi-cycle RV32I controller.
// Holds the FSM state type, opcode values, ALU operation codes,
// ALUOp codes, and datapath mux select encodings.
package ctrl_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RD1   = 2'b10;

    localparam logic [1:0] SRCB_RD2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

endpackage

// File: rtl/alu_decoder.sv
// Combinational ALU operation decoder.
// Ports: alu_op (ALUOp from FSM), funct3, op5 (Instr[5]), funct7_5 (Instr[30])
//        in; alu_control (ALU operation code) out.
module alu_decoder
    import ctrl_pkg::*;
(
    input  logic [1:0] alu_op,
    input  logic [2:0] funct3,
    input  logic       op5,
    input  logic       funct7_5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // Only R-type (op5=1) can encode sub; addi with imm[10] set stays add.
                    3'b000:  alu_control = (op5 & funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Main control FSM for the multi-cycle RV32I core.
// Inputs: clk, rst (async active-high), op/funct3/funct7_5 from the IR,
//         Zero from the ALU, mem_ready memory handshake.
// Outputs: write enables (PCWrite, MemWrite, IRWrite, RegWrite), mux selects
//          (AdrSrc, ResultSrc, ALUSrcA, ALUSrcB, ImmSrc), ALUControl,
//          illegal/retire pulses and the retired-instruction count instret.
module multicycle_controller
    import ctrl_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [6:0]           op,
    input  logic [2:0]           funct3,
    input  logic                 funct7_5,
    input  logic                 Zero,
    input  logic                 mem_ready,
    output logic                 PCWrite,
    output logic                 AdrSrc,
    output logic                 MemWrite,
    output logic                 IRWrite,
    output logic [1:0]           ResultSrc,
    output logic [1:0]           ALUSrcA,
    output logic [1:0]           ALUSrcB,
    output logic [2:0]           ALUControl,
    output logic [1:0]           ImmSrc,
    output logic                 RegWrite,
    output logic                 illegal,
    output logic                 retire,
    output logic [CNT_WIDTH-1:0] instret
);

    state_t     state;
    state_t     state_next;
    logic [1:0] alu_op;
    logic       pc_w, mem_w, ir_w, reg_w, ill, ret;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= S_FETCH;
            instret <= '0;
        end else begin
            state <= state_next;
            if (retire) instret <= instret + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
        end
    end

    always_comb begin
        state_next = state;
        pc_w       = 1'b0;
        mem_w      = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        ill        = 1'b0;
        ret        = 1'b0;
        AdrSrc     = 1'b0;
        ResultSrc  = RES_ALUOUT;
        ALUSrcA    = SRCA_PC;
        ALUSrcB    = SRCB_RD2;
        alu_op     = ALUOP_ADD;
        case (state)
            S_FETCH: begin
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
                ir_w      = mem_ready;
                pc_w      = mem_ready;
                if (mem_ready) state_next = S_DECODE;
            end
            S_DECODE: begin
                // Precompute OldPC+imm so BEQ/JAL find the target in ALUOut.
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
                case (op)
                    OP_LOAD, OP_STORE: state_next = S_MEMADR;
                    OP_R:              state_next = S_EXECUTER;
                    OP_I:              state_next = S_EXECUTEI;
                    OP_BRANCH:         state_next = S_BEQ;
                    OP_JAL:            state_next = S_JAL;
                    default: begin
                        ill        = 1'b1;
                        state_next = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                state_next = op[5] ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                AdrSrc = 1'b1;
                if (mem_ready) state_next = S_MEMWB;
            end
            S_MEMWB: begin
                ResultSrc  = RES_DATA;
                reg_w      = 1'b1;
                ret        = 1'b1;
                state_next = S_FETCH;
            end
            S_MEMWRITE: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
                if (mem_ready) begin
                    ret        = 1'b1;
                    state_next = S_FETCH;
                end
            end
            S_EXECUTER: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_EXECUTEI: begin
                ALUSrcA    = SRCA_RD1;
                ALUSrcB    = SRCB_IMM;
                alu_op     = ALUOP_FUNCT;
                state_next = S_ALUWB;
            end
            S_ALUWB: begin
                reg_w      = 1'b1;
                ret        = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                ALUSrcA    = SRCA_RD1;
                alu_op     = ALUOP_SUB;
                pc_w       = Zero;
                ret        = 1'b1;
                state_next = S_FETCH;
            end
            S_JAL: begin
                // ALU forms OldPC+4 for the link write in ALUWB; PC takes ALUOut target.
                ALUSrcA    = SRCA_OLDPC;
                ALUSrcB    = SRCB_FOUR;
                pc_w       = 1'b1;
                state_next = S_ALUWB;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Gating with rst drops enables and pulses immediately, before any clock edge.
    assign PCWrite  = pc_w  & ~rst;
    assign MemWrite = mem_w & ~rst;
    assign IRWrite  = ir_w  & ~rst;
    assign RegWrite = reg_w & ~rst;
    assign illegal  = ill   & ~rst;
    assign retire   = ret   & ~rst;

    always_comb begin
        case (op)
            OP_STORE:  ImmSrc = 2'b01;
            OP_BRANCH: ImmSrc = 2'b10;
            OP_JAL:    ImmSrc = 2'b11;
            default:   ImmSrc = 2'b00;
        endcase
    end

    alu_decoder u_alu_decoder (
        .alu_op     (alu_op),
        .funct3     (funct3),
        .op5        (op[5]),
        .funct7_5   (funct7_5),
        .alu_control(ALUControl)
    );

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller (counter narrowed to 4 bits so the
// wrap case is reachable in a few instructions).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite, illegal, retire;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic [3:0] instret;

    int total = 0;
    int fails = 0;

    multicycle_controller #(.CNT_WIDTH(4)) dut (
        .clk(clk), .rst(rst), .op(op), .funct3(funct3), .funct7_5(funct7_5),
        .Zero(Zero), .mem_ready(mem_ready), .PCWrite(PCWrite), .AdrSrc(AdrSrc),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .ResultSrc(ResultSrc),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUControl(ALUControl),
        .ImmSrc(ImmSrc), .RegWrite(RegWrite), .illegal(illegal),
        .retire(retire), .instret(instret)
    );

    always #5 clk = ~clk;

    // {PCWrite,AdrSrc,MemWrite,IRWrite,ResultSrc,ALUSrcA,ALUSrcB,ALUControl,RegWrite,illegal,retire}
    logic [15:0] sig;
    assign sig = {PCWrite, AdrSrc, MemWrite, IRWrite, ResultSrc, ALUSrcA, ALUSrcB,
                  ALUControl, RegWrite, illegal, retire};

    function automatic logic [15:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic irw, input logic [1:0] rs,
                                       input logic [1:0] sa, input logic [1:0] sb,
                                       input logic [2:0] alu, input logic rw,
                                       input logic ill, input logic ret);
        return {pcw, adr, mw, irw, rs, sa, sb, alu, rw, ill, ret};
    endfunction

    // Expected output vectors per phase, written out by hand.
    localparam logic [15:0] FETCH_RDY = {1'b1,1'b0,1'b0,1'b1,2'b10,2'b00,2'b10,3'b000,1'b0,1'b0,1'b0};
    localparam logic [15:0] FETCH_STL = {1'b0,1'b0,1'b0,1'b0,2'b10,2'b00,2'b10,3'b000,1'b0,1'b0,1'b0};
    localparam logic [15:0] DECODE    = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,1'b0,1'b0,1'b0};
    localparam logic [15:0] DECODE_IL = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b01,2'b01,3'b000,1'b0,1'b1,1'b0};
    localparam logic [15:0] MEMADR    = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,2'b01,3'b000,1'b0,1'b0,1'b0};
    localparam logic [15:0] MEMREAD   = {1'b0,1'b1,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0,1'b0};
    localparam logic [15:0] MEMWB     = {1'b0,1'b0,1'b0,1'b0,2'b01,2'b00,2'b00,3'b000,1'b1,1'b0,1'b1};
    localparam logic [15:0] MEMWR_STL = {1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0,1'b0};
    localparam logic [15:0] MEMWR_RDY = {1'b0,1'b1,1'b1,1'b0,2'b00,2'b00,2'b00,3'b000,1'b0,1'b0,1'b1};
    localparam logic [15:0] ALUWB     = {1'b0,1'b0,1'b0,1'b0,2'b00,2'b00,2'b00,3'b000,1'b1,1'b0,1'b1};
    localparam logic [15:0] JAL       = {1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,2'b10,3'b000,1'b0,1'b0,1'b0};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Entered 1 time unit after a rising edge; checks mid-cycle, leaves 1 unit after the next edge.
    task automatic step(input string tag, input logic mr, input logic [15:0] exp);
        mem_ready = mr;
        #1;
        check(tag, {16'h0, sig}, {16'h0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; op = 7'b0; funct3 = 3'b0; funct7_5 = 1'b0; Zero = 1'b0; mem_ready = 1'b1;
        #2;
        check("rst_pcwrite", {31'h0, PCWrite}, 32'h0);
        check("rst_irwrite", {31'h0, IRWrite}, 32'h0);
        check("rst_memwrite", {31'h0, MemWrite}, 32'h0);
        check("rst_regwrite", {31'h0, RegWrite}, 32'h0);
        check("rst_instret", {28'h0, instret}, 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // lw: two fetch stalls and one memread stall -> 8 cycles
        op = 7'b0000011;
        step("lw_fetch_stall0", 1'b0, FETCH_STL);
        step("lw_fetch_stall1", 1'b0, FETCH_STL);
        step("lw_fetch", 1'b1, FETCH_RDY);
        step("lw_decode", 1'b1, DECODE);
        step("lw_memadr", 1'b1, MEMADR);
        step("lw_memread_stall", 1'b0, MEMREAD);
        step("lw_memread", 1'b1, MEMREAD);
        step("lw_memwb", 1'b1, MEMWB);
        check("lw_instret", {28'h0, instret}, 32'd1);

        // sub
        op = 7'b0110011; funct3 = 3'b000; funct7_5 = 1'b1;
        step("sub_fetch", 1'b1, FETCH_RDY);
        step("sub_decode", 1'b1, DECODE);
        step("sub_exec", 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,0));
        step("sub_aluwb", 1'b1, ALUWB);
        check("sub_instret", {28'h0, instret}, 32'd2);

        // slt
        funct3 = 3'b010; funct7_5 = 1'b0;
        step("slt_fetch", 1'b1, FETCH_RDY);
        step("slt_decode", 1'b1, DECODE);
        step("slt_exec", 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b101,0,0,0));
        step("slt_aluwb", 1'b1, ALUWB);
        check("slt_instret", {28'h0, instret}, 32'd3);

        // beq taken / not taken (mem_ready low in BEQ must be ignored)
        op = 7'b1100011; funct3 = 3'b000; Zero = 1'b1;
        step("beq1_fetch", 1'b1, FETCH_RDY);
        step("beq1_decode", 1'b1, DECODE);
        step("beq1_beq", 1'b0, mk(1,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,1));
        check("beq1_instret", {28'h0, instret}, 32'd4);
        Zero = 1'b0;
        step("beq0_fetch", 1'b1, FETCH_RDY);
        step("beq0_decode", 1'b1, DECODE);
        step("beq0_beq", 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,1));
        check("beq0_instret", {28'h0, instret}, 32'd5);

        // sw with three memwrite stalls
        op = 7'b0100011;
        step("sw_fetch", 1'b1, FETCH_RDY);
        step("sw_decode", 1'b1, DECODE);
        step("sw_memadr", 1'b1, MEMADR);
        for (int i = 0; i < 3; i++) step("sw_memwrite_stall", 1'b0, MEMWR_STL);
        step("sw_memwrite", 1'b1, MEMWR_RDY);
        check("sw_instret", {28'h0, instret}, 32'd6);

        // jal
        op = 7'b1101111;
        step("jal_fetch", 1'b1, FETCH_RDY);
        step("jal_decode", 1'b1, DECODE);
        step("jal_jal", 1'b1, JAL);
        step("jal_aluwb", 1'b1, ALUWB);
        check("jal_instret", {28'h0, instret}, 32'd7);

        // andi (I-type funct decode; funct7_5 set must not matter)
        op = 7'b0010011; funct3 = 3'b111; funct7_5 = 1'b1;
        step("andi_fetch", 1'b1, FETCH_RDY);
        step("andi_decode", 1'b1, DECODE);
        step("andi_exec", 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b010,0,0,0));
        step("andi_aluwb", 1'b1, ALUWB);
        check("andi_instret", {28'h0, instret}, 32'd8);

        // addi with funct7_5=1 stays add
        funct3 = 3'b000;
        step("addi_fetch", 1'b1, FETCH_RDY);
        step("addi_decode", 1'b1, DECODE);
        step("addi_exec", 1'b1, mk(0,0,0,0,2'b00,2'b10,2'b01,3'b000,0,0,0));
        step("addi_aluwb", 1'b1, ALUWB);
        check("addi_instret", {28'h0, instret}, 32'd9);

        // illegal opcode
        op = 7'b0000000;
        step("ill_fetch", 1'b1, FETCH_RDY);
        step("ill_decode", 1'b1, DECODE_IL);
        step("ill_back_fetch", 1'b0, FETCH_STL);
        check("ill_instret", {28'h0, instret}, 32'd9);

        // ImmSrc from op while parked in FETCH
        op = 7'b0000011; #1; check("imm_lw", {30'h0, ImmSrc}, 32'd0);
        op = 7'b0100011; #1; check("imm_sw", {30'h0, ImmSrc}, 32'd1);
        op = 7'b1100011; #1; check("imm_beq", {30'h0, ImmSrc}, 32'd2);
        op = 7'b1101111; #1; check("imm_jal", {30'h0, ImmSrc}, 32'd3);
        op = 7'b0110011; #1; check("imm_r", {30'h0, ImmSrc}, 32'd0);
        @(posedge clk); #1;

        // counter wrap: 9 -> 15 -> 0 with 7 beqs
        op = 7'b1100011; Zero = 1'b1;
        for (int i = 0; i < 7; i++) begin
            step("wrap_fetch", 1'b1, FETCH_RDY);
            step("wrap_decode", 1'b1, DECODE);
            step("wrap_beq", 1'b1, mk(1,0,0,0,2'b00,2'b10,2'b00,3'b001,0,0,1));
            check("wrap_instret", {28'h0, instret}, (32'd10 + 32'(i)) % 32'd16);
        end

        // reset in the middle of a stalled store
        op = 7'b0100011;
        step("rsw_fetch", 1'b1, FETCH_RDY);
        step("rsw_decode", 1'b1, DECODE);
        step("rsw_memadr", 1'b1, MEMADR);
        step("rsw_memwrite_stall", 1'b0, MEMWR_STL);
        mem_ready = 1'b1;
        #1;
        check("rsw_memwrite_pre", {31'h0, MemWrite}, 32'h1);
        rst = 1'b1;
        #1;
        check("rsw_memwrite_rst", {31'h0, MemWrite}, 32'h0);
        check("rsw_pcwrite_rst", {31'h0, PCWrite}, 32'h0);
        check("rsw_retire_rst", {31'h0, retire}, 32'h0);
        check("rsw_instret_rst", {28'h0, instret}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        step("rsw_after_fetch", 1'b0, FETCH_STL);
        check("rsw_after_instret", {28'h0, instret}, 32'h0);

        $display("%0d/%0d checks passed", total - fails, total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL timeout: observed no finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
